// File: rtl/da_rr_scheduler_pkg.sv
// Shared definitions for the round-robin distributed-arithmetic scheduler:
// FSM state encoding and a constant-friendly ceiling log2.
package da_rr_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Never returns less than 1 so that a 1-wide index still exists when value <= 2.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/da_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found when
// scanning upward from rr_ptr+1, wrapping modulo N.
module rr_arbiter
  import da_rr_scheduler_pkg::*;
#(
  parameter int N = 4
)
(
  input  logic [N-1:0]          req,
  input  logic [clog2(N)-1:0]   rr_ptr,
  output logic [N-1:0]          grant,
  output logic [clog2(N)-1:0]   grant_idx,
  output logic                  any_req
);

  localparam int IW = clog2(N);

  int             pos;
  logic [IW-1:0]  idx;
  logic           found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = |req;
    found     = 1'b0;
    pos       = 0;
    idx       = '0;
    // i = N wraps back to rr_ptr itself, so the last winner is checked last.
    for (int i = 1; i <= N; i++) begin
      pos = int'(rr_ptr) + i;
      if (pos >= N) pos = pos - N;
      idx = IW'(pos);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/da_rr_scheduler.sv
// Shares one bit-serial DA datapath and its external LUT among N channels,
// serving them round-robin and emitting one tagged sum-of-products per job.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting; on any req capture winner's taps, update rr_ptr
// ST_LOAD  | ack pulse to the captured channel, arm the bit counter
// ST_SHIFT | B shift-accumulate steps through the shared LUT
// ST_DONE  | publish y / y_chan with a one-cycle y_valid
module da_rr_scheduler
  import da_rr_scheduler_pkg::*;
#(
  parameter int N = 4,
  parameter int L = 3,
  parameter int B = 3,
  parameter int T = 3
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          req,
  input  logic [N*L*B-1:0]      x_in,
  output logic [N-1:0]          ack,
  output logic [L-1:0]          table_in,
  input  logic [T-1:0]          table_out,
  output logic [B+T-1:0]        y,
  output logic                  y_valid,
  output logic [clog2(N)-1:0]   y_chan,
  output logic                  busy
);

  localparam int W  = B + T;
  localparam int IW = clog2(N);
  localparam int CW = clog2(B);

  state_t         state;
  logic [IW-1:0]  rr_ptr;
  logic [IW-1:0]  sel;
  logic [IW-1:0]  grant_idx;
  logic [N-1:0]   grant;
  logic           any_req;
  logic [B-1:0]   tap_q [L];
  logic [B-1:0]   tap_d [L];
  logic [W-1:0]   p;
  logic [CW-1:0]  cnt;

  rr_arbiter #(.N(N)) u_arb (
    .req       (req),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  always_comb begin
    for (int k = 0; k < L; k++) begin
      tap_d[k] = '0;
      for (int c = 0; c < N; c++) begin
        if (grant_idx == IW'(c)) tap_d[k] = x_in[(c*L + k)*B +: B];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < L; k++) table_in[k] = tap_q[k][0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      ack     <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      y_chan  <= '0;
      busy    <= 1'b0;
      p       <= '0;
      cnt     <= '0;
      rr_ptr  <= IW'(N - 1);
      sel     <= '0;
      for (int k = 0; k < L; k++) tap_q[k] <= '0;
    end else begin
      ack     <= '0;
      y_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            for (int k = 0; k < L; k++) tap_q[k] <= tap_d[k];
            p      <= '0;
            sel    <= grant_idx;
            rr_ptr <= grant_idx;
            ack    <= grant;
            busy   <= 1'b1;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          cnt   <= CW'(B - 1);
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          // LSB-first bits: each step halves the partial sum and adds the
          // new LUT term at the MSB weight.
          p <= (p >> 1) + (W'(table_out) << (B - 1));
          for (int k = 0; k < L; k++) tap_q[k] <= tap_q[k] >> 1;
          if (cnt == '0) state <= ST_DONE;
          else           cnt   <= cnt - 1'b1;
        end
        ST_DONE: begin
          y       <= p;
          y_chan  <= sel;
          y_valid <= 1'b1;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
